// File: rtl/token_controller_if.sv
// Axon-event valid/ready channel from the tick sequencer to the crossbar/neuron datapath.
interface token_controller_if #(
    parameter int AXON_ID_W = 8
) ();
    logic                 axon_valid;
    logic [AXON_ID_W-1:0] axon_id;
    logic                 axon_ready;

    modport master (output axon_valid, output axon_id, input axon_ready);
    modport slave  (input axon_valid, input axon_id, output axon_ready);
endinterface

// File: rtl/token_controller.sv
// Per-tick sequencer: reads the tick's spike vector, dispatches active axons lowest-first,
// runs the neuron phase, then clears/advances the scheduler. Also tracks overruns and errors.
module token_controller #(
    parameter int NUM_AXONS    = 256,
    parameter int AXON_ID_W    = 8,
    parameter int SCHED_RD_LAT = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tick_in,
    output logic                 sched_read_request,
    input  logic [NUM_AXONS-1:0] sched_spikes,
    output logic                 sched_clear_request,
    input  logic                 sched_error,
    output logic                 sched_error_ack,
    token_controller_if.master   axon,
    output logic                 neuron_start,
    input  logic                 neuron_done,
    output logic                 tick_done,
    output logic                 busy,
    output logic [AXON_ID_W:0]   spike_count,
    output logic [7:0]           overrun_count,
    output logic                 err_seen
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_REQ,
        S_RD_WAIT,
        S_SCAN,
        S_NEURON,
        S_CLEAR,
        S_DONE
    } state_t;

    localparam logic [7:0] WAIT_LAST = 8'(SCHED_RD_LAT - 1);

    state_t                 state_q, state_d;
    logic [NUM_AXONS-1:0]   vec_q, vec_d;
    logic [AXON_ID_W:0]     cnt_q, cnt_d;
    logic [7:0]             wait_q, wait_d;
    logic                   nfirst_q, nfirst_d;
    logic [7:0]             over_q, over_d;
    logic                   err_seen_q, err_seen_d;
    logic                   ack_q, ack_d;
    logic                   armed_q, armed_d;

    logic [AXON_ID_W-1:0]   sel_id;
    logic                   enc_hit;
    logic                   any_c;
    logic                   valid_c, rdreq_c, clear_c, nstart_c, done_c;

    // Lowest set bit wins.
    always_comb begin
        sel_id  = '0;
        enc_hit = 1'b0;
        for (int unsigned i = 0; i < NUM_AXONS; i++) begin
            if (vec_q[i] && !enc_hit) begin
                sel_id  = AXON_ID_W'(i);
                enc_hit = 1'b1;
            end
        end
    end

    assign any_c = |vec_q;

    always_comb begin
        state_d  = state_q;
        vec_d    = vec_q;
        cnt_d    = cnt_q;
        wait_d   = wait_q;
        nfirst_d = 1'b0;
        valid_c  = 1'b0;
        rdreq_c  = 1'b0;
        clear_c  = 1'b0;
        nstart_c = 1'b0;
        done_c   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (tick_in) state_d = S_RD_REQ;
            end
            S_RD_REQ: begin
                rdreq_c = 1'b1;
                wait_d  = '0;
                state_d = S_RD_WAIT;
            end
            S_RD_WAIT: begin
                if (wait_q == WAIT_LAST) begin
                    vec_d   = sched_spikes;
                    cnt_d   = '0;
                    state_d = S_SCAN;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            S_SCAN: begin
                valid_c = any_c;
                if (!any_c) begin
                    state_d  = S_NEURON;
                    nfirst_d = 1'b1;
                end else if (axon.axon_ready) begin
                    vec_d[sel_id] = 1'b0;
                    cnt_d         = cnt_q + 1'b1;
                end
            end
            // First NEURON cycle only fires the start pulse; done counts from the second.
            S_NEURON: begin
                nstart_c = nfirst_q;
                if (!nfirst_q && neuron_done) state_d = S_CLEAR;
            end
            S_CLEAR: begin
                clear_c = 1'b1;
                state_d = S_DONE;
            end
            S_DONE: begin
                done_c  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        over_d = over_q;
        if (tick_in && (state_q != S_IDLE) && (over_q != 8'hFF)) over_d = over_q + 1'b1;
    end

    // Ack once per error episode; re-arm only after the error input has been seen low.
    always_comb begin
        err_seen_d = err_seen_q | sched_error;
        ack_d      = 1'b0;
        armed_d    = armed_q;
        if (sched_error) begin
            if (armed_q) begin
                ack_d   = 1'b1;
                armed_d = 1'b0;
            end
        end else begin
            armed_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            vec_q      <= '0;
            cnt_q      <= '0;
            wait_q     <= '0;
            nfirst_q   <= 1'b0;
            over_q     <= '0;
            err_seen_q <= 1'b0;
            ack_q      <= 1'b0;
            armed_q    <= 1'b1;
        end else begin
            state_q    <= state_d;
            vec_q      <= vec_d;
            cnt_q      <= cnt_d;
            wait_q     <= wait_d;
            nfirst_q   <= nfirst_d;
            over_q     <= over_d;
            err_seen_q <= err_seen_d;
            ack_q      <= ack_d;
            armed_q    <= armed_d;
        end
    end

    assign axon.axon_valid     = valid_c;
    assign axon.axon_id        = sel_id;
    assign sched_read_request  = rdreq_c;
    assign sched_clear_request = clear_c;
    assign neuron_start        = nstart_c;
    assign tick_done           = done_c;
    assign busy                = (state_q != S_IDLE);
    assign spike_count         = cnt_q;
    assign overrun_count       = over_q;
    assign err_seen            = err_seen_q;
    assign sched_error_ack     = ack_q;

endmodule
